memory_access_unit: RTL
=======================

# memory_access_unit

Memory-stage data-access controller. Consumes the EX/MEM pipeline register outputs, runs loads and stores against the data memory over a req/ready/rvalid handshake, and returns `stall_m` to hold the EX/MEM register until the access completes. It delivers the loaded word and a completion pulse toward the MEM/WB register.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, 255: maximum cycles spent in REQ+RESP before the access is aborted; 8-bit counter, legal range 1–255.

Ports:
- `clk`  in  1  Rising-edge clock. This is the only clock.
- `reset`  in  1  Synchronous, active-low reset.
- `result_src_m`  in  2  From EX/MEM. The value 2'b01 marks a load.
- `mem_write_m`  in  4  From EX/MEM. Byte-lane store strobes; nonzero marks a store.
- `alu_result_m`  in  32  From EX/MEM. Effective address.
- `write_data_m`  in  32  From EX/MEM. Raw rs2 value.
- `stall_m`  out  1  Holds the EX/MEM register (its StallM input).
- `dmem_req`  out  1  Request valid.
- `dmem_we`  out  1  1 = store, 0 = load.
- `dmem_addr`  out  32  Word-aligned address: {alu_result_m[31:2],2'b00}.
- `dmem_wstrb`  out  4  Store byte strobes. Always 0 for loads.
- `dmem_wdata`  out  32  Lane-replicated store data.
- `dmem_ready`  in  1  Memory accepts the request this cycle.
- `dmem_rvalid`  in  1  Load data valid.
- `dmem_rdata`  in  32  Load data.
- `read_data_o`  out  32  Loaded word, valid while `access_done_o` = 1.
- `access_done_o`  out  1  One-cycle completion pulse.
- `misaligned_o`  out  1  One-cycle pulse for an illegal strobe pattern.
- `timeout_o`  out  1  One-cycle pulse when an access is aborted by timeout.

## Operation
Access detection:
- `mem_write_m` ≠ 0 → store.
- Otherwise, `result_src_m` = 2'b01 → load.
- If both hold, the store wins.
- Anything else is not an access.

State machine: IDLE, REQ, RESP, DONE.
- **IDLE**
  - No access: `stall_m` = 0, stay in IDLE.
  - Access present: `stall_m` = 1 combinationally, register the dmem_* fields, go to REQ.
  - Store with an illegal strobe pattern: no request; go to DONE with `misaligned_o` = 1.
  - Legal strobes: 0001, 0010, 0100, 1000, 0011, 1100, 1111.
- **REQ**
  - `dmem_req` = 1, `stall_m` = 1.
  - On `dmem_ready`:
    - store → DONE;
    - load with `dmem_rvalid` in the same cycle → capture `dmem_rdata`, go to DONE;
    - load without `dmem_rvalid` → RESP.
- **RESP**
  - `dmem_req` = 0, `stall_m` = 1.
  - On `dmem_rvalid`: capture `dmem_rdata` into `read_data_o`, go to DONE.
- **DONE**
  - `stall_m` = 0, `access_done_o` = 1, go to IDLE.
  - The EX/MEM register loads the next instruction at the end of this cycle, so the same instruction is never served twice.

Store data replication, selected by strobe popcount:
- 1 lane → {4{write_data_m[7:0]}}.
- 2 lanes → {2{write_data_m[15:0]}}.
- 4 lanes → write_data_m.

Loads:
- Always a full-word read.
- Byte/half extraction and sign-extension are done in WB from `alu_result[1:0]`.

Timeout:
- The counter clears on entry to REQ and increments every cycle in REQ or RESP.
- When the count reaches `TIMEOUT_CYCLES` → DONE with `timeout_o` = 1 and `read_data_o` = 0.
- `dmem_req` drops that same cycle.
- A late `dmem_rvalid` arriving in IDLE is ignored.

## Timing
- Reset (`reset` = 0 at a clock edge):
  - State → IDLE.
  - `dmem_req`, `dmem_we`, `dmem_wstrb`, `dmem_addr`, `dmem_wdata`, `read_data_o`, `access_done_o`, `misaligned_o`, `timeout_o` → 0.
  - `stall_m` = 0 while `reset` = 0.
- Reset mid-transaction abandons the access: `dmem_req` is 0 in the first cycle after reset.
- Handshake:
  - `dmem_addr`, `dmem_we`, `dmem_wstrb`, `dmem_wdata` are registered and held stable while `dmem_req` && !`dmem_ready`.
  - The request completes on the cycle both `dmem_req` and `dmem_ready` are 1.
- Latency, with the access visible in IDLE at cycle N:
  - Store with immediate ready: REQ at N+1, `access_done_o` at N+2. `stall_m` is high for cycles N and N+1.
  - Load with ready at N+1 and rvalid at N+2: `access_done_o` at N+3.
  - Load with ready and rvalid both at N+1: `access_done_o` at N+2.
- Each cycle of `dmem_ready` delay adds one cycle in REQ; each cycle of `dmem_rvalid` delay adds one cycle in RESP.
- Non-access instructions pass with zero added stall.

## Test plan
- Word store, addr 0x100, data 0xDEADBEEF, strobes 1111, ready tied high → `dmem_req` for exactly one cycle with `dmem_wdata` = 0xDEADBEEF, `dmem_wstrb` = 1111; `access_done_o` 2 cycles after the access is presented; `stall_m` high for 2 cycles.
- Byte store, data 0x000000A5, strobes 0100, addr 0x202 → `dmem_addr` = 0x200, `dmem_wdata` = 0xA5A5A5A5, `dmem_wstrb` = 0100.
- Load at 0x3C, ready delayed 3 cycles, rvalid 2 cycles after ready with rdata 0x12345678 → `dmem_addr`/`dmem_we` held stable through the waits; `read_data_o` = 0x12345678 with `access_done_o`; `stall_m` high until DONE.
- Store with strobes 0110 → no `dmem_req`; `misaligned_o` and `access_done_o` pulse together 1 cycle later.
- Load with `TIMEOUT_CYCLES` = 4 and ready never asserted → `timeout_o` pulse; `read_data_o` = 0; `dmem_req` low afterward; a late rvalid causes no further pulses.
- Assert reset low while in RESP → next cycle all outputs 0, state IDLE; `stall_m` = 0 while reset is low.

Source files
------------

// File: rtl/memory_access_unit.sv
// memory_access_unit
//
// Memory-stage data-access controller. Watches the EX/MEM register outputs,
// issues one load or store per instruction to the data memory over a
// req/ready/rvalid handshake, and holds the EX/MEM register (stall_m) until
// the access completes. Completion is reported with a one-cycle pulse toward
// the MEM/WB register, together with the loaded word.
//
// Ports:
//   clk, reset          rising-edge clock, synchronous active-low reset
//   result_src_m        EX/MEM result source; 2'b01 marks a load
//   mem_write_m         EX/MEM byte-lane store strobes; nonzero marks a store
//   alu_result_m        EX/MEM effective address
//   write_data_m        EX/MEM raw store value (rs2)
//   stall_m             hold request for the EX/MEM register
//   dmem_req/we/addr/wstrb/wdata   registered request toward data memory
//   dmem_ready          memory accepts the request this cycle
//   dmem_rvalid/rdata   load response
//   read_data_o         loaded word, valid while access_done_o = 1
//   access_done_o       one-cycle completion pulse
//   misaligned_o        one-cycle pulse for an illegal store strobe pattern
//   timeout_o           one-cycle pulse when an access is aborted by timeout

module memory_access_unit #(
  parameter int unsigned TIMEOUT_CYCLES = 32'd255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  result_src_m,
  input  logic [3:0]  mem_write_m,
  input  logic [31:0] alu_result_m,
  input  logic [31:0] write_data_m,
  output logic        stall_m,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_wstrb,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ready,
  input  logic        dmem_rvalid,
  input  logic [31:0] dmem_rdata,
  output logic [31:0] read_data_o,
  output logic        access_done_o,
  output logic        misaligned_o,
  output logic        timeout_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [7:0] TIMEOUT_LIMIT = 8'(TIMEOUT_CYCLES);

  // Only the strobe shapes a naturally aligned byte, half or word can produce.
  function automatic logic strobe_legal(input logic [3:0] strb);
    logic ok;
    case (strb)
      4'b0001, 4'b0010, 4'b0100, 4'b1000,
      4'b0011, 4'b1100, 4'b1111: ok = 1'b1;
      default:                   ok = 1'b0;
    endcase
    return ok;
  endfunction

  // Replicate the low byte/half across the word so whichever lane the
  // strobes select already carries the right data.
  function automatic logic [31:0] replicate_wdata(input logic [3:0]  strb,
                                                  input logic [31:0] data);
    logic [31:0] rep;
    case (strb)
      4'b0001, 4'b0010, 4'b0100, 4'b1000: rep = {4{data[7:0]}};
      4'b0011, 4'b1100:                   rep = {2{data[15:0]}};
      default:                            rep = data;
    endcase
    return rep;
  endfunction

  state_t      state_r;
  logic [7:0]  cnt_r;
  logic        dmem_req_r;
  logic        dmem_we_r;
  logic [31:0] dmem_addr_r;
  logic [3:0]  dmem_wstrb_r;
  logic [31:0] dmem_wdata_r;
  logic [31:0] read_data_r;
  logic        access_done_r;
  logic        misaligned_r;
  logic        timeout_r;

  logic        is_store_s;
  logic        is_load_s;
  logic        is_access_s;
  logic [8:0]  cnt_inc_s;
  logic        expired_s;
  logic        stall_s;
  logic        addr_lsb_unused_s;

  // Store wins over load when both are flagged.
  assign is_store_s  = |mem_write_m;
  assign is_load_s   = !is_store_s && (result_src_m == 2'b01);
  assign is_access_s = is_store_s || is_load_s;

  // Count of cycles spent in REQ+RESP including the current one.
  assign cnt_inc_s = {1'b0, cnt_r} + 9'd1;
  assign expired_s = (cnt_inc_s >= {1'b0, TIMEOUT_LIMIT});

  // Sub-word placement is resolved later in WB from the address LSBs.
  assign addr_lsb_unused_s = ^alu_result_m[1:0];

  // Stall must rise in the same cycle the access appears, so it is decoded
  // from the current state rather than registered.
  always_comb begin
    stall_s = 1'b0;
    if (!reset) begin
      stall_s = 1'b0;
    end else begin
      case (state_r)
        IDLE:       stall_s = is_access_s;
        REQ, RESP:  stall_s = 1'b1;
        DONE:       stall_s = 1'b0;
        default:    stall_s = 1'b0;
      endcase
    end
  end

  // Access state machine with all memory-side and completion outputs registered.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r       <= IDLE;
      cnt_r         <= 8'd0;
      dmem_req_r    <= 1'b0;
      dmem_we_r     <= 1'b0;
      dmem_addr_r   <= 32'd0;
      dmem_wstrb_r  <= 4'd0;
      dmem_wdata_r  <= 32'd0;
      read_data_r   <= 32'd0;
      access_done_r <= 1'b0;
      misaligned_r  <= 1'b0;
      timeout_r     <= 1'b0;
    end else begin
      access_done_r <= 1'b0;
      misaligned_r  <= 1'b0;
      timeout_r     <= 1'b0;
      case (state_r)
        IDLE: begin
          if (is_access_s) begin
            read_data_r <= 32'd0;
            if (is_store_s && !strobe_legal(mem_write_m)) begin
              // Rejected before any request is issued.
              misaligned_r  <= 1'b1;
              access_done_r <= 1'b1;
              state_r       <= DONE;
            end else begin
              dmem_req_r   <= 1'b1;
              dmem_we_r    <= is_store_s;
              dmem_addr_r  <= {alu_result_m[31:2], 2'b00};
              dmem_wstrb_r <= is_store_s ? mem_write_m : 4'b0000;
              dmem_wdata_r <= is_store_s ? replicate_wdata(mem_write_m, write_data_m) : 32'd0;
              cnt_r        <= 8'd0;
              state_r      <= REQ;
            end
          end else begin
            state_r <= IDLE;
          end
        end
        REQ: begin
          cnt_r <= cnt_inc_s[7:0];
          // A real completion on the final allowed cycle beats the timeout.
          if (dmem_ready && (dmem_we_r || dmem_rvalid)) begin
            if (!dmem_we_r) begin
              read_data_r <= dmem_rdata;
            end
            dmem_req_r    <= 1'b0;
            access_done_r <= 1'b1;
            state_r       <= DONE;
          end else if (expired_s) begin
            dmem_req_r    <= 1'b0;
            read_data_r   <= 32'd0;
            timeout_r     <= 1'b1;
            access_done_r <= 1'b1;
            state_r       <= DONE;
          end else if (dmem_ready) begin
            dmem_req_r <= 1'b0;
            state_r    <= RESP;
          end else begin
            state_r <= REQ;
          end
        end
        RESP: begin
          cnt_r <= cnt_inc_s[7:0];
          if (dmem_rvalid) begin
            read_data_r   <= dmem_rdata;
            access_done_r <= 1'b1;
            state_r       <= DONE;
          end else if (expired_s) begin
            read_data_r   <= 32'd0;
            timeout_r     <= 1'b1;
            access_done_r <= 1'b1;
            state_r       <= DONE;
          end else begin
            state_r <= RESP;
          end
        end
        DONE: begin
          // EX/MEM advances at the end of this cycle, so IDLE sees a new instruction.
          state_r <= IDLE;
        end
        default: begin
          dmem_req_r <= 1'b0;
          state_r    <= IDLE;
        end
      endcase
    end
  end

  assign stall_m       = stall_s;
  assign dmem_req      = dmem_req_r;
  assign dmem_we       = dmem_we_r;
  assign dmem_addr     = dmem_addr_r;
  assign dmem_wstrb    = dmem_wstrb_r;
  assign dmem_wdata    = dmem_wdata_r;
  assign read_data_o   = read_data_r;
  assign access_done_o = access_done_r;
  assign misaligned_o  = misaligned_r;
  assign timeout_o     = timeout_r;

endmodule
